// File: rtl/mouse_transmitter.sv
// Host-to-device PS/2 byte transmitter: inhibits the bus, issues request-to-send,
// then shifts data/parity/stop out on device clock falls and checks the acknowledge.
module mouse_transmitter #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    output logic       CLK_MOUSE_OE,
    output logic       DATA_MOUSE_OE,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       ERR_TIMEOUT,
    output logic       ERR_NACK,
    output logic [2:0] state_dbg
);

    localparam int MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        INHIBIT      = 3'd1,
        RTS          = 3'd2,
        SEND         = 3'd3,
        WAIT_ACK     = 3'd4,
        WAIT_RELEASE = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          clk_s;
    logic          data_s;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    tx_byte;
    logic          tx_parity;
    logic          in_xfer;
    logic          timeout_hit;

    assign state_dbg = state;

    // Synchronizers and the edge history reset to 1 so a released bus looks idle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], CLK_MOUSE_IN};
            data_sync <= {data_sync[0], DATA_MOUSE_IN};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    assign in_xfer     = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_RELEASE);
    assign timeout_hit = in_xfer && (cnt == TO_LIMIT);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (SEND_BYTE) next_state = INHIBIT;
            end
            INHIBIT: begin
                if (cnt == INH_LAST) next_state = RTS;
            end
            RTS: begin
                if (cnt == RTS_LAST) next_state = SEND;
            end
            SEND: begin
                if (timeout_hit)                  next_state = IDLE;
                else if (fall && bit_idx == 4'd9) next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (timeout_hit) next_state = IDLE;
                else if (fall)   next_state = data_s ? IDLE : WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (timeout_hit)         next_state = IDLE;
                else if (clk_s && data_s) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Status pulses are combinational so they sit in the last busy cycle.
    always_comb begin
        BUSY        = (state != IDLE);
        ERR_TIMEOUT = timeout_hit;
        ERR_NACK    = 1'b0;
        BYTE_SENT   = 1'b0;
        if (!timeout_hit) begin
            if (state == WAIT_ACK && fall && data_s)      ERR_NACK  = 1'b1;
            if (state == WAIT_RELEASE && clk_s && data_s) BYTE_SENT = 1'b1;
        end
    end

    // One counter serves the inhibit/RTS phase lengths and the inter-edge timeout.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt           <= '0;
            bit_idx       <= 4'd0;
            tx_byte       <= 8'h00;
            tx_parity     <= 1'b0;
            CLK_MOUSE_OE  <= 1'b0;
            DATA_MOUSE_OE <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (SEND_BYTE) begin
                        tx_byte       <= BYTE_TO_SEND;
                        tx_parity     <= ~^BYTE_TO_SEND;
                        bit_idx       <= 4'd0;
                        CLK_MOUSE_OE  <= 1'b1;
                        DATA_MOUSE_OE <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt           <= '0;
                        DATA_MOUSE_OE <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RTS: begin
                    if (cnt == RTS_LAST) begin
                        cnt          <= '0;
                        bit_idx      <= 4'd0;
                        CLK_MOUSE_OE <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (timeout_hit) begin
                        cnt           <= '0;
                        CLK_MOUSE_OE  <= 1'b0;
                        DATA_MOUSE_OE <= 1'b0;
                    end else if (fall) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx < 4'd8) begin
                            DATA_MOUSE_OE <= ~tx_byte[bit_idx[2:0]];
                        end else if (bit_idx == 4'd8) begin
                            DATA_MOUSE_OE <= ~tx_parity;
                        end else begin
                            DATA_MOUSE_OE <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_ACK, WAIT_RELEASE: begin
                    if (timeout_hit) begin
                        cnt           <= '0;
                        CLK_MOUSE_OE  <= 1'b0;
                        DATA_MOUSE_OE <= 1'b0;
                    end else if (fall) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt           <= '0;
                    CLK_MOUSE_OE  <= 1'b0;
                    DATA_MOUSE_OE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mouse_transmitter.md
MOUSE_TRANSMITTER -- requirements
Module: mouse_transmitter

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000: CLK cycles the mouse clock line is held low before request-to-send (100 us at 100 MHz).
REQ-002 Parameter RTS_CYCLES, default 20: CLK cycles both lines are held low before the clock is released.
REQ-003 Parameter TIMEOUT_CYCLES, default 2000000: maximum CLK cycles between device clock falling edges (20 ms) before abort.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-006 CLK_MOUSE_IN  input  1  PS/2 clock pad level, asynchronous.
REQ-007 DATA_MOUSE_IN  input  1  PS/2 data pad level, asynchronous.
REQ-008 CLK_MOUSE_OE  output  1  1 = drive clock pad low; 0 = release (open-drain).
REQ-009 DATA_MOUSE_OE  output  1  1 = drive data pad low; 0 = release.
REQ-010 SEND_BYTE  input  1  one-cycle request to transmit BYTE_TO_SEND.
REQ-011 BYTE_TO_SEND  input  8  byte to transmit; sampled only on an accepted SEND_BYTE.
REQ-012 BUSY  output  1  high from acceptance until return to IDLE.
REQ-013 BYTE_SENT  output  1  one-cycle pulse on successful, acknowledged transfer.
REQ-014 ERR_TIMEOUT  output  1  one-cycle pulse on timeout abort.
REQ-015 ERR_NACK  output  1  one-cycle pulse when device acknowledge is missing.

Function
REQ-016 CLK_MOUSE_IN and DATA_MOUSE_IN shall each pass a 2-flop synchronizer; a falling edge is a synchronized 1->0 transition, detected no more than 3 CLK cycles after the pad edge.
REQ-017 States: IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_RELEASE; DATA_MOUSE_OE follows the current transmit bit; both OEs are registered outputs.
REQ-018 IDLE: both OEs 0, BUSY 0; SEND_BYTE=1 latches BYTE_TO_SEND, computes odd parity (XNOR of the 8 bits), and moves to INHIBIT.
REQ-019 SEND_BYTE while BUSY=1 shall be ignored, with no effect on the latched byte or state.
REQ-020 INHIBIT: CLK_MOUSE_OE=1, DATA_MOUSE_OE=0 for exactly INHIBIT_CYCLES, then RTS.
REQ-021 RTS: CLK_MOUSE_OE=1, DATA_MOUSE_OE=1 (start bit 0) for exactly RTS_CYCLES, then SEND with CLK_MOUSE_OE=0.
REQ-022 SEND: a 4-bit index starts at 0; on falling edges 1..8 drive data bit 0..7 (LSB first); edge 9 drives parity; edge 10 releases data (stop bit 1); then WAIT_ACK.
REQ-023 Driving bit value b means DATA_MOUSE_OE = ~b.
REQ-024 WAIT_ACK: on the next falling edge sample synchronized data; 0 goes to WAIT_RELEASE, 1 pulses ERR_NACK and returns to IDLE.
REQ-025 WAIT_RELEASE: when both synchronized lines are 1, pulse BYTE_SENT and return to IDLE.
REQ-026 The timeout counter clears on entry to SEND and on each falling edge.
REQ-027 In SEND, WAIT_ACK and WAIT_RELEASE, reaching TIMEOUT_CYCLES releases both lines, pulses ERR_TIMEOUT, and returns to IDLE.
REQ-028 BYTE_SENT, ERR_NACK and ERR_TIMEOUT are mutually exclusive and coincide with the transition to IDLE (BUSY=0 the following cycle).
REQ-029 Falling edges seen in IDLE, INHIBIT or RTS shall be ignored.

Reset
REQ-030 RESET=0 at any time, including mid-transfer, sets state IDLE, CLK_MOUSE_OE=0, DATA_MOUSE_OE=0, BUSY=0, BYTE_SENT=0, ERR_TIMEOUT=0, ERR_NACK=0, and clears all counters and synchronizers to 1 (lines idle).
REQ-031 After RESET returns to 1, the block shall not start a transfer without a new SEND_BYTE.

Verification
REQ-032 Send 0xF4, device model clocks at 12.5 kHz and acks -> CLK low 10000 cycles; data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one BYTE_SENT pulse.
REQ-033 Send 0xFF -> parity bit 1; send 0x00 -> parity bit 1; both acknowledged with BYTE_SENT.
REQ-034 Send 0xF4 with no device clocks -> lines released and ERR_TIMEOUT pulse exactly TIMEOUT_CYCLES after SEND entry; BUSY=0 afterward.
REQ-035 Device leaves data high at ack clock -> ERR_NACK pulse, no BYTE_SENT.
REQ-036 SEND_BYTE with 0xAA during a 0xF4 transfer -> ignored; 0xF4 bits transmitted unchanged.
REQ-037 RESET=0 after edge 5 of SEND -> both OEs 0 with no CLK edge; no status pulse; next SEND_BYTE starts a fresh INHIBIT.
